// File: rtl/multiply_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the multiply block.
package multiply_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width able to hold the value w (the iteration count loaded on accept).
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiply_fsm.sv
// Control FSM and iteration down-counter for the shift-and-add multiplier.
// Optional MULTIPLY_ZERO_SKIP_EN: zero operands jump straight from IDLE to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// BUSY  | one multiplier bit per clock; counter runs WIDTH..1
// DONE  | product visible on c, done pulses for this one cycle
module multiply_fsm
  import multiply_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic zero_i,
  output logic accept_o,
  output logic iter_o,
  output logic last_o,
  output logic skip_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          skip;

  assign accept_o = (state_q == IDLE) && start_i;
  assign iter_o   = (state_q == BUSY);
  assign last_o   = iter_o && (cnt_q == CW'(1));

`ifdef MULTIPLY_ZERO_SKIP_EN
  assign skip = accept_o && zero_i;
`else
  logic unused_zero;
  assign unused_zero = zero_i;
  assign skip        = 1'b0;
`endif

  assign skip_o = skip;
  assign busy_o = busy_q;
  assign done_o = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (skip) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (accept_o) begin
            state_q <= BUSY;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          // Terminal count: the edge doing the last add also enters DONE.
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multiply.sv
// Iterative radix-2 unsigned shift-and-add multiplier; datapath plus FSM instance.
// Optional MULTIPLY_ZERO_SKIP_EN shortens zero-operand requests (handled in multiply_fsm).
module multiply
  import multiply_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    c_q;
  logic             accept;
  logic             iter;
  logic             last;
  logic             skip;
  logic             zero;

  assign zero = (a == '0) || (b == '0);

  multiply_fsm #(
    .WIDTH(WIDTH)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .zero_i  (zero),
    .accept_o(accept),
    .iter_o  (iter),
    .last_o  (last),
    .skip_o  (skip),
    .busy_o  (busy),
    .done_o  (done)
  );

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      c_q      <= '0;
    end else begin
      if (accept) begin
        mcand_q  <= PW'(a);
        mplier_q <= b;
        acc_q    <= '0;
      end else if (iter) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_d;
      end
      // c only moves on the edge entering DONE, so it is stable for the whole run.
      if (last) begin
        c_q <= acc_d;
      end else if (skip) begin
        c_q <= '0;
      end
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_multiply.sv
// Directed self-checking bench for the multiply block (WIDTH = 8).
module tb_multiply;

  localparam int W = 8;
`ifdef MULTIPLY_ZERO_SKIP_EN
  localparam int ZERO_EDGES = 1;
  localparam int ZERO_BUSY  = 0;
`else
  localparam int ZERO_EDGES = 9;
  localparam int ZERO_BUSY  = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2*W-1:0] c;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  multiply #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Called at a negedge; edges counts posedges since (and including) the accepting edge.
  task automatic wait_done(input int e0, output int edges, output int busy_cycles, output bit seen);
    edges = e0;
    busy_cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (busy) busy_cycles++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        edges++;
      end
    end
  endtask

  task automatic test_reset();
    int edges, bc;
    bit seen;
    #12;
    n_cmp++; if (c !== 16'd0) begin n_bad++; $display("FAIL reset_c got=%0d want=0", c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk);
    rst_n = 1'b1; a = 8'd10; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_start_busy got=%b want=1", busy); end
    wait_done(1, edges, bc, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL first_start_timeout got=no_done want=done"); end
    else if (c !== 16'd20) begin n_bad++; $display("FAIL first_start_c got=%0d want=20", c); end
  endtask

  task automatic test_product(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2*W-1:0] exp,
                              input int exp_edges, input int exp_busy, input string name);
    int edges, bc;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v;
    wait_done(1, edges, bc, seen);
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s_timeout got=no_done want=done", name);
    end else begin
      n_cmp++; if (edges != exp_edges) begin n_bad++; $display("FAIL %s_latency got=%0d want=%0d", name, edges, exp_edges); end
      n_cmp++; if (bc != exp_busy) begin n_bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, exp_busy); end
      n_cmp++; if (c !== exp) begin n_bad++; $display("FAIL %s_c got=%0d want=%0d", name, c, exp); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse got=%b want=0", name, done); end
      n_cmp++; if (c !== exp) begin n_bad++; $display("FAIL %s_c_hold got=%0d want=%0d", name, c, exp); end
    end
  endtask

  task automatic test_start_while_busy();
    int edges, ndone, done_edge;
    logic [2*W-1:0] c_at;
    ndone = 0; done_edge = 0; c_at = '0;
    @(negedge clk);
    a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 4;
    for (int k = 0; k < 20; k++) begin
      if (done) begin ndone++; done_edge = edges; c_at = c; end
      @(negedge clk);
      edges++;
    end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL busy_start_done_count got=%0d want=1", ndone); end
    n_cmp++; if (done_edge != 9) begin n_bad++; $display("FAIL busy_start_latency got=%0d want=9", done_edge); end
    n_cmp++; if (c_at !== 16'd65025) begin n_bad++; $display("FAIL busy_start_c got=%0d want=65025", c_at); end
    n_cmp++; if (c !== 16'd65025) begin n_bad++; $display("FAIL busy_start_c_hold got=%0d want=65025", c); end
  endtask

  task automatic test_start_in_done();
    int edges, bc;
    bit seen;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, edges, bc, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL done_start_timeout got=no_done want=done"); end
    a = 8'd10; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_start_ignored_busy got=%b want=0", busy); end
    n_cmp++; if (c !== 16'd15) begin n_bad++; $display("FAIL done_start_ignored_c got=%0d want=15", c); end
  endtask

  task automatic test_back_to_back();
    int edges, bc, gap;
    bit seen;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, edges, bc, seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
    @(negedge clk);
    gap = edges + 1;
    a = 8'd10; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%b want=1 gap=%0d", busy, gap); end
    wait_done(1, edges, bc, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL b2b_second_timeout got=no_done want=done"); end
    else if (c !== 16'd20) begin n_bad++; $display("FAIL b2b_second_c got=%0d want=20", c); end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (c !== 16'd0) begin n_bad++; $display("FAIL midrst_c got=%0d want=0", c); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", done); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
    n_cmp++; if (c !== 16'd0) begin n_bad++; $display("FAIL midrst_c_after got=%0d want=0", c); end
  endtask

  initial begin
    test_reset();
    test_product(8'd3, 8'd5, 16'd15, 9, 8, "3x5");
    test_product(8'd10, 8'd2, 16'd20, 9, 8, "10x2");
    test_product(8'd255, 8'd2, 16'd510, 9, 8, "255x2");
    test_product(8'd255, 8'd255, 16'hFE01, 9, 8, "255x255");
    test_product(8'd128, 8'd129, 16'd16512, 9, 8, "128x129");
    test_start_while_busy();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_run();
    test_product(8'd0, 8'd7, 16'd0, ZERO_EDGES, ZERO_BUSY, "0x7");
    test_product(8'd9, 8'd0, 16'd0, ZERO_EDGES, ZERO_BUSY, "9x0");
    test_product(8'd1, 8'd1, 16'd1, 9, 8, "1x1");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiply.md
MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; result width is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle request; captures a and b when the block is idle.
REQ-005 Port: a  input  WIDTH  unsigned multiplicand.
REQ-006 Port: b  input  WIDTH  unsigned multiplier.
REQ-007 Port: c  output  2*WIDTH  unsigned product, registered, held until the next accepted start.
REQ-008 Port: busy  output  1  high while a multiplication is in progress.
REQ-009 Port: done  output  1  single-cycle pulse in the cycle that c first shows the new product.

Function
REQ-010 Algorithm: iterative radix-2 shift-and-add, unsigned, one multiplier bit per clock.
REQ-011 FSM states: IDLE, BUSY, DONE.
REQ-012 FSM transitions: IDLE->BUSY on start; BUSY->DONE after WIDTH iterations; DONE->IDLE unconditionally after one cycle.
REQ-013 Start acceptance: start is accepted only in IDLE; the a and b values on that edge are latched.
REQ-014 Start during BUSY or DONE: ignored; it has no effect on the computation, on c or on the latched operands.
REQ-015 Latency: for WIDTH=8, done is high on the clock cycle WIDTH+1 edges after the accepting edge; busy is high for exactly WIDTH cycles.
REQ-016 Result update: c updates only on the edge entering DONE; a and b changes after acceptance do not affect c.
REQ-017 Overflow: none; the full 2*WIDTH product is exact (255*255 = 65025 = 16'hFE01).
REQ-018 Back-to-back: start asserted in the cycle after done is accepted.
REQ-019 Operation gap: the minimum gap between accepted starts is WIDTH+2 cycles.

Reset
REQ-020 rst_n low: FSM forced to IDLE asynchronously; c=0, busy=0, done=0; internal accumulator and operand registers cleared.
REQ-021 Reset asserted mid-operation: the operation is aborted; no done pulse is produced for it; c reads 0.
REQ-022 Reset release: the first start is accepted on the first rising edge with rst_n high.

Configuration
REQ-023 Macro MULTIPLY_ZERO_SKIP_EN defined: if the latched a or b is zero, the FSM goes IDLE->DONE directly; done fires one cycle after acceptance with c=0.
REQ-024 Macro MULTIPLY_ZERO_SKIP_EN undefined: zero operands take the full WIDTH+1 cycle latency.
REQ-025 Result values with or without MULTIPLY_ZERO_SKIP_EN: identical for all operands.

Structure
REQ-026 Package multiply_pkg: holds the default WIDTH constant and the FSM state enumeration typedef.
REQ-027 Sub-module multiply_fsm: contains the control FSM and iteration counter; the datapath (shift registers, adder, c register) stays in multiply.

Verification
REQ-028 Case 3x5: a=3, b=5, start pulse -> done after 9 cycles, c=15, busy high 8 cycles.
REQ-029 Case 10x2: a=10, b=2 -> c=20.
REQ-030 Case 255x2: a=255, b=2 -> c=510.
REQ-031 Case 255x255: a=255, b=255 -> c=65025.
REQ-032 Start while busy, and operands changed mid-run: a=255, b=255, start again at cycle 3 with a=1, b=1 -> c=65025; only one done pulse.
REQ-033 Reset mid-run, and zero-skip timing: rst_n low at cycle 4 -> c=0, busy=0, no done. With MULTIPLY_ZERO_SKIP_EN, a=0, b=7 -> done 1 cycle after start, c=0.
